// File: rtl/bram_ctrl_pkg.sv
// Shared types and defaults for the dp_bram4096 write-side controller.
package bram_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; last_i = 1 means requester 1 won most recently.
module rr_arbiter2 (
  input  logic en_i,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  always_comb begin
    gnt0_o = en_i & valid0_i & (~valid1_i | last_i);
    gnt1_o = en_i & valid1_i & (~valid0_i | ~last_i);
  end

endmodule

// File: rtl/bram_write_ctrl.sv
// Owns the dp_bram4096 write port: full-memory clear sequencing plus
// round-robin sharing between two valid/ready write requesters.
module bram_write_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter  int unsigned          WIDTH      = DEFAULT_WIDTH,
  parameter  logic [WIDTH-1:0]     RESET_FILL = '0,
  localparam int unsigned          DEPTH      = 4096 / WIDTH,
  localparam int unsigned          ADDRW      = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clear_in,
  input  logic [WIDTH-1:0] clear_val_in,
  output logic             busy_out,
  input  logic             req0_valid_in,
  input  logic [ADDRW-1:0] req0_addr_in,
  input  logic [WIDTH-1:0] req0_data_in,
  output logic             req0_ready_out,
  input  logic             req1_valid_in,
  input  logic [ADDRW-1:0] req1_addr_in,
  input  logic [WIDTH-1:0] req1_data_in,
  output logic             req1_ready_out,
  output logic             mem_en_out,
  output logic [ADDRW-1:0] mem_addr_out,
  output logic [WIDTH-1:0] mem_data_out
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

  state_t           state_q;
  logic [ADDRW-1:0] cnt_q;
  logic [WIDTH-1:0] fill_q;
  logic             done_q;
  logic             last_q;
  logic             mem_en_q;
  logic [ADDRW-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_data_q;

  logic arb_en_d;
  logic gnt0_d;
  logic gnt1_d;
  logic hs_d;

  assign arb_en_d = (state_q == RUN) && !clear_in;

  rr_arbiter2 u_arb (
    .en_i     (arb_en_d),
    .valid0_i (req0_valid_in),
    .valid1_i (req1_valid_in),
    .last_i   (last_q),
    .gnt0_o   (gnt0_d),
    .gnt1_o   (gnt1_d)
  );

  assign hs_d           = gnt0_d | gnt1_d;
  assign req0_ready_out = gnt0_d;
  assign req1_ready_out = gnt1_d;
  assign busy_out       = (state_q == CLEAR);
  assign mem_en_out     = mem_en_q;
  assign mem_addr_out   = mem_addr_q;
  assign mem_data_out   = mem_data_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      fill_q     <= RESET_FILL;
      done_q     <= 1'b0;
      last_q     <= 1'b1;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else if (clear_in) begin
      // The requesting edge already issues address 0, so the sweep continues
      // from 1 and the last clear write lands DEPTH cycles after the request.
      state_q    <= CLEAR;
      fill_q     <= clear_val_in;
      cnt_q      <= ADDRW'(1);
      done_q     <= 1'b0;
      mem_en_q   <= 1'b1;
      mem_addr_q <= '0;
      mem_data_q <= clear_val_in;
    end else begin
      case (state_q)
        CLEAR: begin
          if (done_q) begin
            state_q  <= RUN;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mem_en_q <= 1'b0;
          end else begin
            mem_en_q   <= 1'b1;
            mem_addr_q <= cnt_q;
            mem_data_q <= fill_q;
            if (cnt_q == LAST_ADDR) begin
              done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + ADDRW'(1);
            end
          end
        end
        RUN: begin
          mem_en_q <= hs_d;
          if (gnt0_d) begin
            mem_addr_q <= req0_addr_in;
            mem_data_q <= req0_data_in;
          end else if (gnt1_d) begin
            mem_addr_q <= req1_addr_in;
            mem_data_q <= req1_data_in;
          end
          if (hs_d) begin
            last_q <= gnt1_d;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_write_ctrl.sv
// Directed bench for bram_write_ctrl with WIDTH=8 (DEPTH=512) and a RAM model.
module tb_bram_write_ctrl;

  localparam int D = 512;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [7:0] clear_val;
  logic       busy;
  logic       r0_valid, r1_valid;
  logic [8:0] r0_addr, r1_addr;
  logic [7:0] r0_data, r1_data;
  logic       r0_ready, r1_ready;
  logic       mem_en;
  logic [8:0] mem_addr;
  logic [7:0] mem_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  ram [D];
  int unsigned wr_cnt = 0;

  bram_write_ctrl #(.WIDTH(8), .RESET_FILL(8'h00)) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .clear_in       (clear),
    .clear_val_in   (clear_val),
    .busy_out       (busy),
    .req0_valid_in  (r0_valid),
    .req0_addr_in   (r0_addr),
    .req0_data_in   (r0_data),
    .req0_ready_out (r0_ready),
    .req1_valid_in  (r1_valid),
    .req1_addr_in   (r1_addr),
    .req1_data_in   (r1_data),
    .req1_ready_out (r1_ready),
    .mem_en_out     (mem_en),
    .mem_addr_out   (mem_addr),
    .mem_data_out   (mem_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      ram[mem_addr] <= mem_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic test_reset();
    rst_n = 1'b1; clear = 1'b0; clear_val = 8'h00;
    r0_valid = 1'b1; r0_addr = 9'h0AA; r0_data = 8'h33;
    r1_valid = 1'b1; r1_addr = 9'h0BB; r1_data = 8'h44;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_en, mem_addr, mem_data, busy} !== {1'b0, 9'd0, 8'h00, 1'b1})
      begin n_fail++; $display("FAIL reset_outputs: got en=%b addr=%0d data=%h busy=%b, want 0 0 00 1", mem_en, mem_addr, mem_data, busy); end
    n_checks++;
    if ({r0_ready, r1_ready} !== 2'b00)
      begin n_fail++; $display("FAIL reset_readies: got %b%b, want 00", r0_ready, r1_ready); end
    r0_valid = 1'b0; r1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_clear();
    int unsigned start;
    int bad;
    start = wr_cnt;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_en, mem_addr, mem_data, busy} !== {1'b1, 9'(i), 8'h00, 1'b1})
        begin n_fail++; $display("FAIL reset_clear_write[%0d]: got en=%b addr=%0d data=%h busy=%b, want 1 %0d 00 1", i, mem_en, mem_addr, mem_data, busy, i); end
    end
    @(negedge clk);
    n_checks++;
    if ({mem_en, busy} !== 2'b00)
      begin n_fail++; $display("FAIL reset_clear_end: got en=%b busy=%b, want 0 0", mem_en, busy); end
    n_checks++;
    if (wr_cnt - start !== 512)
      begin n_fail++; $display("FAIL reset_clear_count: got %0d writes, want 512", wr_cnt - start); end
    bad = 0;
    for (int i = 0; i < D; i++) if (ram[i] !== 8'h00) bad++;
    n_checks++;
    if (bad !== 0)
      begin n_fail++; $display("FAIL reset_clear_ram: got %0d words not 00, want 0", bad); end
  endtask

  task automatic test_contention();
    int unsigned start;
    start = wr_cnt;
    r0_valid = 1'b1; r0_addr = 9'd10; r0_data = 8'hA0;
    r1_valid = 1'b1; r1_addr = 9'd20; r1_data = 8'hB0;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if ({r0_ready, r1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
        begin n_fail++; $display("FAIL contention_grant[%0d]: got %b%b, want %s", k, r0_ready, r1_ready, (k % 2 == 0) ? "10" : "01"); end
      if (k > 0) begin
        n_checks++;
        if ({mem_en, mem_addr, mem_data} !== ((k % 2 == 1) ? {1'b1, 9'd10, 8'hA0} : {1'b1, 9'd20, 8'hB0}))
          begin n_fail++; $display("FAIL contention_write[%0d]: got en=%b addr=%0d data=%h", k, mem_en, mem_addr, mem_data); end
      end
      @(negedge clk);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    n_checks++;
    if ({mem_en, mem_addr, mem_data} !== {1'b1, 9'd20, 8'hB0})
      begin n_fail++; $display("FAIL contention_last_write: got en=%b addr=%0d data=%h, want 1 20 b0", mem_en, mem_addr, mem_data); end
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b0)
      begin n_fail++; $display("FAIL contention_idle: got en=%b, want 0", mem_en); end
    n_checks++;
    if (wr_cnt - start !== 6)
      begin n_fail++; $display("FAIL contention_count: got %0d writes, want 6", wr_cnt - start); end
  endtask

  task automatic test_single();
    int unsigned start;
    start = wr_cnt;
    r0_valid = 1'b1; r0_addr = 9'h1A3; r0_data = 8'h5C;
    #1;
    n_checks++;
    if ({r0_ready, r1_ready} !== 2'b10)
      begin n_fail++; $display("FAIL single_ready: got %b%b, want 10", r0_ready, r1_ready); end
    @(negedge clk);
    r0_valid = 1'b0;
    n_checks++;
    if ({mem_en, mem_addr, mem_data} !== {1'b1, 9'h1A3, 8'h5C})
      begin n_fail++; $display("FAIL single_write: got en=%b addr=%h data=%h, want 1 1a3 5c", mem_en, mem_addr, mem_data); end
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b0 || wr_cnt - start !== 1)
      begin n_fail++; $display("FAIL single_count: got en=%b writes=%0d, want 0 1", mem_en, wr_cnt - start); end
  endtask

  task automatic test_clear_in_run();
    int bad;
    r1_valid = 1'b1; r1_addr = 9'h055; r1_data = 8'h77;
    clear = 1'b1; clear_val = 8'hFF;
    #1;
    n_checks++;
    if ({r0_ready, r1_ready} !== 2'b00)
      begin n_fail++; $display("FAIL clear_run_block: got %b%b, want 00", r0_ready, r1_ready); end
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      clear = 1'b0;
      n_checks++;
      if ({mem_en, mem_addr, mem_data, busy, r1_ready} !== {1'b1, 9'(i), 8'hFF, 1'b1, 1'b0})
        begin n_fail++; $display("FAIL clear_run_write[%0d]: got en=%b addr=%0d data=%h busy=%b rdy1=%b, want 1 %0d ff 1 0", i, mem_en, mem_addr, mem_data, busy, r1_ready, i); end
    end
    @(negedge clk);
    n_checks++;
    if ({mem_en, busy, r1_ready} !== 3'b001)
      begin n_fail++; $display("FAIL clear_run_resume: got en=%b busy=%b rdy1=%b, want 0 0 1", mem_en, busy, r1_ready); end
    @(negedge clk);
    r1_valid = 1'b0;
    n_checks++;
    if ({mem_en, mem_addr, mem_data} !== {1'b1, 9'h055, 8'h77})
      begin n_fail++; $display("FAIL clear_run_stalled_write: got en=%b addr=%h data=%h, want 1 055 77", mem_en, mem_addr, mem_data); end
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < D; i++) if (ram[i] !== ((i == 'h55) ? 8'h77 : 8'hFF)) bad++;
    n_checks++;
    if (bad !== 0)
      begin n_fail++; $display("FAIL clear_run_ram: got %0d wrong words, want 0", bad); end
  endtask

  task automatic test_clear_restart();
    int bad;
    clear = 1'b1; clear_val = 8'h11;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      clear = 1'b0;
      n_checks++;
      if ({mem_en, mem_addr, mem_data, busy} !== {1'b1, 9'(i), 8'h11, 1'b1})
        begin n_fail++; $display("FAIL restart_first[%0d]: got en=%b addr=%0d data=%h busy=%b, want 1 %0d 11 1", i, mem_en, mem_addr, mem_data, busy, i); end
    end
    clear = 1'b1; clear_val = 8'h22;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      clear = 1'b0;
      n_checks++;
      if ({mem_en, mem_addr, mem_data, busy} !== {1'b1, 9'(i), 8'h22, 1'b1})
        begin n_fail++; $display("FAIL restart_second[%0d]: got en=%b addr=%0d data=%h busy=%b, want 1 %0d 22 1", i, mem_en, mem_addr, mem_data, busy, i); end
    end
    @(negedge clk);
    n_checks++;
    if ({mem_en, busy} !== 2'b00)
      begin n_fail++; $display("FAIL restart_end: got en=%b busy=%b, want 0 0", mem_en, busy); end
    bad = 0;
    for (int i = 0; i < D; i++) if (ram[i] !== 8'h22) bad++;
    n_checks++;
    if (bad !== 0)
      begin n_fail++; $display("FAIL restart_ram: got %0d words not 22, want 0", bad); end
  endtask

  task automatic test_async_reset();
    int bad;
    clear = 1'b1; clear_val = 8'h5A;
    for (int i = 0; i <= 300; i++) begin
      @(negedge clk);
      clear = 1'b0;
      n_checks++;
      if ({mem_en, mem_addr, mem_data} !== {1'b1, 9'(i), 8'h5A})
        begin n_fail++; $display("FAIL async_pre[%0d]: got en=%b addr=%0d data=%h, want 1 %0d 5a", i, mem_en, mem_addr, mem_data, i); end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_en, mem_addr, mem_data, busy} !== {1'b0, 9'd0, 8'h00, 1'b1})
      begin n_fail++; $display("FAIL async_reset_now: got en=%b addr=%0d data=%h busy=%b, want 0 0 00 1", mem_en, mem_addr, mem_data, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_en, mem_addr, mem_data, busy} !== {1'b1, 9'(i), 8'h00, 1'b1})
        begin n_fail++; $display("FAIL async_clear[%0d]: got en=%b addr=%0d data=%h busy=%b, want 1 %0d 00 1", i, mem_en, mem_addr, mem_data, busy, i); end
    end
    @(negedge clk);
    n_checks++;
    if ({mem_en, busy} !== 2'b00)
      begin n_fail++; $display("FAIL async_end: got en=%b busy=%b, want 0 0", mem_en, busy); end
    bad = 0;
    for (int i = 0; i < D; i++) if (ram[i] !== 8'h00) bad++;
    n_checks++;
    if (bad !== 0)
      begin n_fail++; $display("FAIL async_ram: got %0d words not 00, want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_reset_clear();
    test_contention();
    test_single();
    test_clear_in_run();
    test_clear_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_write_ctrl.md
# bram_write_ctrl

Write-side controller for the 4096-bit dual-port block RAM (`dp_bram4096`). It owns the RAM's single write port, with two jobs:
- sequence a full-memory clear after reset or on request;
- share the write port between two requesters (CPU store path, UART loader) using a round-robin valid/ready handshake.

The read port is not touched; it stays wired directly to its consumer.

## Interface
- `WIDTH`, 8, RAM word width in bits
- `DEPTH`, 4096/`WIDTH`, word count (derived, localparam)
- `ADDRW`, $clog2(`DEPTH`), address width (derived, localparam)
- `RESET_FILL`, 0, fill value for the post-reset clear
- `clk_in` in 1, single clock, all state on rising edge
- `rst_n_in` in 1, reset, asynchronous, active-low
- `clear_in` in 1, one-cycle clear request
- `clear_val_in` in `WIDTH`, fill value, sampled with `clear_in`
- `busy_out` out 1, clear in progress
- `req0_valid_in` in 1, requester 0 write valid
- `req0_addr_in` in `ADDRW`, requester 0 address
- `req0_data_in` in `WIDTH`, requester 0 data
- `req0_ready_out` out 1, requester 0 granted
- `req1_valid_in`, `req1_addr_in`, `req1_data_in`, `req1_ready_out`: same as requester 0, for requester 1
- `mem_en_out` out 1, to RAM `en_in`
- `mem_addr_out` out `ADDRW`, to RAM `addr_in`
- `mem_data_out` out `WIDTH`, to RAM `data_in`

## Operation
- Two states: `CLEAR` and `RUN`.
- **Reset:** state `CLEAR`, clear counter 0, fill = `RESET_FILL`, round-robin pointer `last` = 1 (requester 0 wins first).
- **`CLEAR`:**
  - Each cycle issues one write: counter → address, fill → data. Counter increments.
  - After address `DEPTH`-1 is issued, go to `RUN`.
  - Both readies are 0.
- **`RUN`:**
  - `rdyN` = `reqN_valid_in` AND granted.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester ≠ `last`.
  - `last` updates only on a completed handshake.
- **Handshake:** `valid` & `ready` in the same cycle. Address and data are registered to the `mem_*` outputs. Requesters hold `valid`/`addr`/`data` stable until `ready`.
- **`clear_in` in `RUN`:**
  - Latch `clear_val_in` as the fill value; counter ← 0; go to `CLEAR`.
  - Both readies are forced 0 that cycle, so no handshake completes.
- **`clear_in` in `CLEAR`:** restart the counter at 0 with the newly latched fill value.
- **Requests during `CLEAR`:** stall only; they are never dropped.
- **Counter:** `ADDRW` bits wide. Terminal detect is at `DEPTH`-1; no wrap past it.

## Timing
- **Reset values:**
  - `mem_en_out` 0, `mem_addr_out` 0, `mem_data_out` 0.
  - `busy_out` 1.
  - `req0_ready_out` and `req1_ready_out` 0.
- **Readies:** combinational from the valids, state and `last`. No combinational path from any input to the `mem_*` outputs.
- **Write latency:** handshake in cycle t → `mem_en_out` = 1 with address/data in cycle t+1. The RAM commits at the end of t+1. Back-to-back handshakes give one write per cycle.
- **Post-reset clear:**
  - First edge after release presents address 0 in the next cycle.
  - Addresses 0..`DEPTH`-1 occupy `DEPTH` consecutive cycles with `mem_en_out` high.
  - `busy_out` falls in the cycle after the last clear write. Readies may assert in that same cycle.
- **`clear_in` sampled at edge t:** `busy_out` is 1 from t+1. Writes run at t+1..t+`DEPTH`. `busy_out` is 0 at t+`DEPTH`+1.
- **A handshake completed in the cycle before `clear_in`:** its write still issues. Request writes and clear writes never overlap.
- **Async reset mid-clear or mid-write:** all registers return to reset values immediately. Any pending registered write is dropped.

## Structure
- Package `bram_ctrl_pkg`:
  - `state_t` enum {`CLEAR`, `RUN`}.
  - `DEFAULT_WIDTH` constant.
- Sub-module `rr_arbiter2`:
  - Combinational two-way grant from two valids, the `last` pointer and an enable.
  - Used for the request path.
- The top level holds the state register, counter, fill register and output registers.

## Test plan
All scenarios use `WIDTH`=8, `DEPTH`=512, `RESET_FILL`=0.
- **Reset clear:** release reset, no requests → 512 consecutive writes, addr 0..511, data 0x00; then `busy_out`=0; RAM model all zero.
- **Single request:** after clear, req0 writes addr 0x1A3, data 0x5C → `req0_ready_out` in the same cycle; `mem_en_out`=1, addr 0x1A3, data 0x5C one cycle later; no other writes.
- **Contention:** both valid continuously for 6 cycles (req0 addr 10, data 0xA0; req1 addr 20, data 0xB0) → grants alternate 0,1,0,1,0,1; six writes, no stalls.
- **Clear in `RUN`:** pulse `clear_in` with `clear_val_in`=0xFF while req1 is valid → no handshake that cycle; 512 writes of 0xFF; req1's handshake completes in the first `RUN` cycle and its write issues next.
- **Clear restart:** pulse `clear_in` (0x11), then again after 100 cycles (0x22) → the counter restarts at 0; the final RAM contents are all 0x22; `busy_out` falls 512 cycles after the second pulse.
- **Async reset mid-clear:** assert `rst_n_in` at clear address 300 → `mem_en_out`=0 and `busy_out`=1 immediately; after release, a full clear starts from address 0 with 0x00.
